// File: rtl/icache_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the instruction cache.
// The arbiter connects through the slave modport; the requester/cache side uses master.
interface icache_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req0_en;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_do;
  logic              req0_ack;
  logic              req1_en;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_do;
  logic              req1_ack;
  logic              cache_en;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_do;
  logic              cache_do_ack;

  modport slave (
    input  req0_en, req0_addr, req1_en, req1_addr, cache_do, cache_do_ack,
    output req0_do, req0_ack, req1_do, req1_ack, cache_en, cache_addr
  );

  modport master (
    output req0_en, req0_addr, req1_en, req1_addr, cache_do, cache_do_ack,
    input  req0_do, req0_ack, req1_do, req1_ack, cache_en, cache_addr
  );
endinterface

// File: rtl/icache_arbiter.sv
// Round-robin arbiter sharing one instruction-cache port between fetch (req0) and a
// secondary requester (req1); one access outstanding at a time, all outputs registered.
module icache_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic req0_ack,
  input logic req1_ack,
  input logic cache_en
);
  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) !(req0_ack && req1_ack));
  a_ack_idle_bus: assert property (@(posedge clk) disable iff (reset)
                                   (req0_ack || req1_ack) |-> !cache_en);
endmodule

module icache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  icache_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic              pick;
  logic              cache_en_q, cache_en_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [DATA_W-1:0] req0_do_q, req0_do_d;
  logic [DATA_W-1:0] req1_do_q, req1_do_d;
  logic              req0_ack_q, req0_ack_d;
  logic              req1_ack_q, req1_ack_d;

  // Next-state and next-output computation for the grant/complete/release sequence.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    cache_en_d   = cache_en_q;
    cache_addr_d = cache_addr_q;
    req0_do_d    = req0_do_q;
    req1_do_d    = req1_do_q;
    req0_ack_d   = req0_ack_q;
    req1_ack_d   = req1_ack_q;
    pick         = 1'b0;

    case (state_q)
      IDLE: begin
        // Pointer only matters under contention; a lone requester always wins.
        if (bus.req0_en && bus.req1_en) begin
          pick = ptr_q;
        end else if (bus.req1_en) begin
          pick = 1'b1;
        end else begin
          pick = 1'b0;
        end

        if (bus.req0_en || bus.req1_en) begin
          cache_addr_d = pick ? bus.req1_addr : bus.req0_addr;
          cache_en_d   = 1'b1;
          gnt_d        = pick;
          state_d      = BUSY;
        end else begin
          cache_en_d   = 1'b0;
          state_d      = IDLE;
        end
      end

      BUSY: begin
        if (bus.cache_do_ack) begin
          if (gnt_q) begin
            req1_do_d  = bus.cache_do;
            req1_ack_d = 1'b1;
          end else begin
            req0_do_d  = bus.cache_do;
            req0_ack_d = 1'b1;
          end
          cache_en_d = 1'b0;
          ptr_d      = ~gnt_q;
          state_d    = DONE;
        end else begin
          state_d    = BUSY;
        end
      end

      DONE: begin
        // Requester en is deliberately not sampled here: it may still be dropping.
        req0_ack_d = 1'b0;
        req1_ack_d = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        cache_en_d = 1'b0;
        req0_ack_d = 1'b0;
        req1_ack_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      gnt_q        <= 1'b0;
      cache_en_q   <= 1'b0;
      cache_addr_q <= {ADDR_W{1'b0}};
      req0_do_q    <= {DATA_W{1'b0}};
      req1_do_q    <= {DATA_W{1'b0}};
      req0_ack_q   <= 1'b0;
      req1_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      cache_en_q   <= cache_en_d;
      cache_addr_q <= cache_addr_d;
      req0_do_q    <= req0_do_d;
      req1_do_q    <= req1_do_d;
      req0_ack_q   <= req0_ack_d;
      req1_ack_q   <= req1_ack_d;
    end
  end

  assign bus.cache_en   = cache_en_q;
  assign bus.cache_addr = cache_addr_q;
  assign bus.req0_do    = req0_do_q;
  assign bus.req1_do    = req1_do_q;
  assign bus.req0_ack   = req0_ack_q;
  assign bus.req1_ack   = req1_ack_q;

  icache_arbiter_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .req0_ack (req0_ack_q),
    .req1_ack (req1_ack_q),
    .cache_en (cache_en_q)
  );
endmodule

// File: tb/tb_icache_arbiter.sv
// Directed bench for icache_arbiter: bench plays both requesters and the cache,
// expected values are hand-derived per scenario.
module tb_icache_arbiter;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  logic [31:0] exp_do [2];

  icache_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  icache_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_do[0] = 32'h0;
    exp_do[1] = 32'h0;
  endtask

  // Serve one access: wait for grant, hold d busy cycles, ack with data, check result.
  task automatic access(input logic p, input logic [15:0] addr, input logic [31:0] data,
                        input int d, input logic [1:0] drop);
    int n;
    n = 0;
    while (bus.cache_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk_val("grant", {63'h0, bus.cache_en}, 64'h1);
    chk_val("cache_addr", {48'h0, bus.cache_addr}, {48'h0, addr});
    for (int i = 0; i < d; i++) begin
      tick();
      chk_val("busy_hold", {47'h0, bus.cache_en, bus.cache_addr}, {47'h0, 1'b1, addr});
    end
    bus.cache_do     = data;
    bus.cache_do_ack = 1'b1;
    tick();
    bus.cache_do_ack = 1'b0;
    bus.cache_do     = 32'h0;
    exp_do[p] = data;
    chk_val("ack0", {63'h0, bus.req0_ack}, {63'h0, ~p});
    chk_val("ack1", {63'h0, bus.req1_ack}, {63'h0, p});
    chk_val("do0", {32'h0, bus.req0_do}, {32'h0, exp_do[0]});
    chk_val("do1", {32'h0, bus.req1_do}, {32'h0, exp_do[1]});
    chk_val("en_release", {63'h0, bus.cache_en}, 64'h0);
    if (drop[0]) bus.req0_en = 1'b0;
    else         bus.req0_en = bus.req0_en;
    if (drop[1]) bus.req1_en = 1'b0;
    else         bus.req1_en = bus.req1_en;
    tick();
    chk_val("ack_clear", {62'h0, bus.req0_ack, bus.req1_ack}, 64'h0);
    chk_val("done_en", {63'h0, bus.cache_en}, 64'h0);
    chk_val("do_keep", {bus.req0_do, bus.req1_do}, {exp_do[0], exp_do[1]});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    bus.req0_en      = 1'b0;
    bus.req0_addr    = 16'h0;
    bus.req1_en      = 1'b0;
    bus.req1_addr    = 16'h0;
    bus.cache_do     = 32'h0;
    bus.cache_do_ack = 1'b0;
    do_reset();

    // Reset values
    chk_val("rst_en", {63'h0, bus.cache_en}, 64'h0);
    chk_val("rst_addr", {48'h0, bus.cache_addr}, 64'h0);
    chk_val("rst_acks", {62'h0, bus.req0_ack, bus.req1_ack}, 64'h0);
    chk_val("rst_do", {bus.req0_do, bus.req1_do}, 64'h0);

    // Single fetch, cache answers 2 cycles after cache_en rises
    bus.req0_en   = 1'b1;
    bus.req0_addr = 16'h0040;
    tick();
    chk_val("grant_lat", {63'h0, bus.cache_en}, 64'h1);
    access(1'b0, 16'h0040, 32'hDEADBEEF, 1, 2'b01);

    // Contention from reset: req0 first, then req1
    do_reset();
    bus.req0_en   = 1'b1;
    bus.req0_addr = 16'h0010;
    bus.req1_en   = 1'b1;
    bus.req1_addr = 16'h0020;
    access(1'b0, 16'h0010, 32'h0A0A0A0A, 0, 2'b01);
    access(1'b1, 16'h0020, 32'h0B0B0B0B, 0, 2'b10);

    // Sustained contention for 6 accesses; pointer is back on req0
    bus.req0_en   = 1'b1;
    bus.req0_addr = 16'h0100;
    bus.req1_en   = 1'b1;
    bus.req1_addr = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        access(1'b0, 16'h0100, 32'h11111111, 1, (i == 5) ? 2'b11 : 2'b00);
      else
        access(1'b1, 16'h0200, 32'h22222222, 1, (i == 5) ? 2'b11 : 2'b00);
    end

    // req0 withdraws mid-BUSY; its access still completes, then req1 is served
    bus.req0_en   = 1'b1;
    bus.req0_addr = 16'h0030;
    bus.req1_en   = 1'b1;
    bus.req1_addr = 16'h0050;
    tick();
    bus.req0_en = 1'b0;
    access(1'b0, 16'h0030, 32'hA5A5A5A5, 1, 2'b00);
    access(1'b1, 16'h0050, 32'h5A5A5A5A, 0, 2'b10);

    // Stray cache ack while idle changes nothing
    bus.cache_do     = 32'hFFFFFFFF;
    bus.cache_do_ack = 1'b1;
    tick();
    bus.cache_do_ack = 1'b0;
    bus.cache_do     = 32'h0;
    chk_val("stray_en", {63'h0, bus.cache_en}, 64'h0);
    chk_val("stray_addr", {48'h0, bus.cache_addr}, 64'h0050);
    chk_val("stray_acks", {62'h0, bus.req0_ack, bus.req1_ack}, 64'h0);
    chk_val("stray_do", {bus.req0_do, bus.req1_do}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    tick();
    chk_val("stray_acks2", {62'h0, bus.req0_ack, bus.req1_ack}, 64'h0);

    // Leave the pointer on req1, then abandon a req1 access with reset
    bus.req0_en   = 1'b1;
    bus.req0_addr = 16'h0060;
    access(1'b0, 16'h0060, 32'h60606060, 0, 2'b01);
    bus.req1_en   = 1'b1;
    bus.req1_addr = 16'h0077;
    tick();
    chk_val("r1_grant", {47'h0, bus.cache_en, bus.cache_addr}, {47'h0, 1'b1, 16'h0077});
    tick();
    bus.req1_en = 1'b0;
    do_reset();
    chk_val("midrst_en", {63'h0, bus.cache_en}, 64'h0);
    chk_val("midrst_addr", {48'h0, bus.cache_addr}, 64'h0);
    chk_val("midrst_acks", {62'h0, bus.req0_ack, bus.req1_ack}, 64'h0);
    chk_val("midrst_do", {bus.req0_do, bus.req1_do}, 64'h0);
    bus.cache_do     = 32'hCAFEF00D;
    bus.cache_do_ack = 1'b1;
    tick();
    bus.cache_do_ack = 1'b0;
    bus.cache_do     = 32'h0;
    chk_val("late_ack_acks", {62'h0, bus.req0_ack, bus.req1_ack}, 64'h0);
    chk_val("late_ack_do", {bus.req0_do, bus.req1_do}, 64'h0);
    bus.req0_en   = 1'b1;
    bus.req0_addr = 16'h0011;
    bus.req1_en   = 1'b1;
    bus.req1_addr = 16'h0022;
    access(1'b0, 16'h0011, 32'h13572468, 0, 2'b01);
    access(1'b1, 16'h0022, 32'h24681357, 0, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
